id_pipe_stage: RTL and testbench
================================

// Module: id_pipe_stage
// PURPOSE
//  Registered RV32I decode stage. Decodes if_ir into the ID/EX control bundle, operand indices and
//  sign-extended immediate, then holds them in the ID/EX pipeline register.
//  - valid/ready handshake on both sides.
//  - Load-use hazard detection with a programmable bubble count.
//  - Store width decode (sb/sh/sw).
//  Sits between the IF stage register and ex_stage.
// PARAMETERS
//  XLEN      32  data/PC width; immediates sign-extended to XLEN
//  ALUOP_W   5   ALUOp field width (alu.vh codes)
//  LU_BUBBLE 1   bubble cycles inserted on load-use hazard, legal 1..3
// PORTS
//  clk        in   1            clock, rising edge
//  rst_n      in   1            asynchronous active-low reset
//  flush      in   1            branch/jump redirect; kills held and incoming instr
//  if_valid   in   1            if_ir/if_pc valid
//  if_ready   out  1            stage accepts if_ir this cycle
//  if_ir      in   32           instruction word
//  if_pc      in   XLEN         PC of if_ir
//  ex_ready   in   1            EX accepts ID/EX contents this cycle
//  ex_memread in   2            MemRead of instr currently in EX (nonzero = load)
//  ex_rd      in   5            rd of instr currently in EX
//  id_valid   out  1            ID/EX register holds a live instr
//  id_ctrl    out  17+ALUOP_W   {RS1_Z,RS1_PC,ALUorSHIFT,RegDst,DMSE,ALUOp,ALUSrc,MemRead[1:0],
//                               MemWrite[1:0],Branch,RegWrite,MemtoReg[1:0],FT[2:0]}
//  id_rs1     out  5            IR[19:15]
//  id_rs2     out  5            IR[24:20]
//  id_rd      out  5            IR[11:7]
//  id_imm     out  XLEN         sign-extended immediate, selected by FT (I/S/B/U/J)
//  id_pc      out  XLEN         PC of held instr
//  id_illegal out  1            held instr is illegal (ID_ILLEGAL_TRAP_EN only, else 0)
// BEHAVIOUR
//  - Reset: id_valid=0, id_ctrl=0, id_rs1/rs2/rd=0, id_imm=0, id_pc=0, id_illegal=0,
//    bubble counter=0, state RUN.
//  - Decode per inst.vh/riscv.vh.
//    - MemWrite: 00 none, 01 sb, 10 sh, 11 sw; f3 other than 000/001/010 gives 00.
//    - MemRead/DMSE: lb/lh/lw=01/10/11 with DMSE=1; lbu/lhu=01/10 with DMSE=0.
//    - Branch ALUOp comes from f3; JAL/JALR MemtoReg=10; load MemtoReg=01.
//    - Unlisted opcode/f3/f7 combinations decode to all-zero ctrl (a NOP).
//  - Latency: 1 cycle. Instr accepted on edge N appears on id_* after edge N.
//  - Load advance: register loads when if_valid && if_ready.
//    if_ready = state==RUN && !hazard && (!id_valid || ex_ready).
//  - Hazard: ex_memread!=0 && ex_rd!=0 && (ex_rd==rs1 of if_ir || (ex_rd==rs2 && opcode is
//    BR/STORE/FUNC2)). LUI/AUIPC/JAL never hazard on rs1.
//  - FSM RUN/STALL.
//    - RUN: if if_valid && hazard && (!id_valid || ex_ready), load a bubble (id_valid=0,
//      ctrl=0), set cnt=LU_BUBBLE-1. Go to STALL if cnt>0, else stay RUN.
//    - STALL: id_valid=0, if_ready=0, cnt decrements each ex_ready cycle; cnt==0 gives RUN.
//  - Hold: id_valid && !ex_ready keeps all id_* stable; if_ready=0.
//  - Flush has priority over everything. Next edge: id_valid=0, ctrl=0, state RUN, cnt=0,
//    incoming if_ir discarded.
//  - Flush and hazard in the same cycle resolve to flush.
//  - Reset asserted mid-stall returns to reset values immediately (async).
// CONFIGURATION
//  ID_ILLEGAL_TRAP_EN
//    Defined: unknown opcode, bad f3/f7, or IR[1:0]!=11 sets id_illegal=1 with
//    id_valid=1 and ctrl=0.
//    Undefined: such instrs load as a NOP with id_valid=1; id_illegal tied to 0.
// TESTING
//  1. Reset (rst_n=0 mid-run) -> all id_* = 0, id_valid=0 asynchronously, if_ready=1 after release.
//  2. if_ir=0x00500093 (addi x1,x0,5), pc=0x100 -> next cycle: id_imm=5, RegWrite=1, ALUSrc=1,
//     ALUOp=IADD, id_rd=1, id_pc=0x100.
//  3. ex_memread=11, ex_rd=2, if_ir=0x001101b3 (add x3,x2,x1), LU_BUBBLE=2 -> two bubble cycles
//     (id_valid=0, if_ready=0), then add loads.
//  4. if_ir=0x00209223 (sh x2,4(x1)) -> MemWrite=10, id_imm=4, RegWrite=0, FT=FT_S.
//  5. ex_ready=0 for 3 cycles with add held -> id_* stable, if_ready=0; flush during STALL ->
//     id_valid=0, state RUN.
//  6. if_ir=0xFFFFFFFF -> with ID_ILLEGAL_TRAP_EN id_illegal=1, ctrl=0; without, id_illegal=0,
//     ctrl=0.

Source files
------------

// File: rtl/id_pipe_stage.sv
// id_pipe_stage -- registered RV32I decode stage (IF -> ID/EX register).
//
// Decodes if_ir into the ID/EX control bundle, operand indices and a
// sign-extended immediate, then holds them in the ID/EX register. Valid/ready
// handshake on both sides, load-use hazard detection with a programmable
// bubble count, and flush for branch/jump redirects.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   flush                redirect: kills held and incoming instruction
//   if_valid/if_ready    IF-side handshake; if_ir/if_pc instruction and its PC
//   ex_ready             EX accepts the ID/EX contents this cycle
//   ex_memread, ex_rd    MemRead and rd of the instruction currently in EX
//   id_valid             ID/EX register holds a live instruction
//   id_ctrl              {RS1_Z,RS1_PC,ALUorSHIFT,RegDst,DMSE,ALUOp,ALUSrc,
//                         MemRead[1:0],MemWrite[1:0],Branch,RegWrite,
//                         MemtoReg[1:0],FT[2:0]}
//   id_rs1/rs2/rd        register indices of held instruction
//   id_imm, id_pc        sign-extended immediate and PC of held instruction
//   id_illegal           held instruction is illegal
//
// Build option: define ID_ILLEGAL_TRAP_EN to flag unknown opcodes, bad f3/f7
// or IR[1:0]!=11 on id_illegal. Without it such words load as a NOP and
// id_illegal is tied low.
//
// Local encodings (shared with ex_stage):
//   FT:     0 R, 1 I, 2 S, 3 B, 4 U, 5 J
//   ALUOp:  0 none, 1 ADD, 2 SUB, 3 SLL, 4 SLT, 5 SLTU, 6 XOR, 7 SRL, 8 SRA,
//           9 OR, 10 AND, 16+f3 branch compare
//   MemtoReg: 00 ALU, 01 memory, 10 PC+4
module id_pipe_stage #(
    parameter int XLEN      = 32,
    parameter int ALUOP_W   = 5,
    parameter int LU_BUBBLE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 if_valid,
    output logic                 if_ready,
    input  logic [31:0]          if_ir,
    input  logic [XLEN-1:0]      if_pc,
    input  logic                 ex_ready,
    input  logic [1:0]           ex_memread,
    input  logic [4:0]           ex_rd,
    output logic                 id_valid,
    output logic [16+ALUOP_W:0]  id_ctrl,
    output logic [4:0]           id_rs1,
    output logic [4:0]           id_rs2,
    output logic [4:0]           id_rd,
    output logic [XLEN-1:0]      id_imm,
    output logic [XLEN-1:0]      id_pc,
    output logic                 id_illegal
);
    localparam int CTRL_W = 17 + ALUOP_W;

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_REG   = 7'b0110011;

    localparam logic [2:0] FT_R = 3'd0;
    localparam logic [2:0] FT_I = 3'd1;
    localparam logic [2:0] FT_S = 3'd2;
    localparam logic [2:0] FT_B = 3'd3;
    localparam logic [2:0] FT_U = 3'd4;
    localparam logic [2:0] FT_J = 3'd5;

    localparam logic [ALUOP_W-1:0] ALU_ADD     = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] ALU_BR_BASE = ALUOP_W'(16);

    localparam logic [1:0] BUBBLE_CNT = 2'(LU_BUBBLE - 1);

    typedef enum logic {ST_RUN, ST_STALL} state_t;

    // Arithmetic ALUOp from f3; alt selects SUB/SRA (f7[5]).
    function automatic logic [ALUOP_W-1:0] arith_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  arith_op = alt ? ALUOP_W'(2) : ALUOP_W'(1);
            3'b001:  arith_op = ALUOP_W'(3);
            3'b010:  arith_op = ALUOP_W'(4);
            3'b011:  arith_op = ALUOP_W'(5);
            3'b100:  arith_op = ALUOP_W'(6);
            3'b101:  arith_op = alt ? ALUOP_W'(8) : ALUOP_W'(7);
            3'b110:  arith_op = ALUOP_W'(9);
            default: arith_op = ALUOP_W'(10);
        endcase
    endfunction

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    assign opcode = if_ir[6:0];
    assign f3     = if_ir[14:12];
    assign f7     = if_ir[31:25];

    // ---------------- decode ----------------
    logic               rs1_z, rs1_pc, alu_or_shift, reg_dst, dmse, alu_src;
    logic               branch, reg_write;
    logic [ALUOP_W-1:0] alu_op;
    logic [1:0]         mem_read, mem_write, mem_to_reg;
    logic [2:0]         ft;
    logic [CTRL_W-1:0]  dec_ctrl;
    logic [XLEN-1:0]    dec_imm;

    always_comb begin
        rs1_z = 1'b0; rs1_pc = 1'b0; alu_or_shift = 1'b0; reg_dst = 1'b0;
        dmse = 1'b0; alu_src = 1'b0; branch = 1'b0; reg_write = 1'b0;
        alu_op = '0; mem_read = 2'b00; mem_write = 2'b00; mem_to_reg = 2'b00;
        ft = FT_R;
        // Anything not matched below leaves the bundle all-zero (a NOP).
        case (opcode)
            OP_LUI, OP_AUIPC: begin
                rs1_z   = (opcode == OP_LUI);
                rs1_pc  = (opcode == OP_AUIPC);
                alu_op  = ALU_ADD; alu_src = 1'b1;
                reg_write = 1'b1; reg_dst = 1'b1; ft = FT_U;
            end
            OP_JAL: begin
                rs1_pc  = 1'b1; alu_op = ALU_ADD; alu_src = 1'b1;
                reg_write = 1'b1; reg_dst = 1'b1; mem_to_reg = 2'b10; ft = FT_J;
            end
            OP_JALR: if (f3 == 3'b000) begin
                alu_op  = ALU_ADD; alu_src = 1'b1;
                reg_write = 1'b1; reg_dst = 1'b1; mem_to_reg = 2'b10; ft = FT_I;
            end
            OP_BR: if (f3[2:1] != 2'b01) begin
                branch = 1'b1; alu_op = ALU_BR_BASE | ALUOP_W'(f3); ft = FT_B;
            end
            OP_LOAD: if (f3 != 3'b011 && f3[2:1] != 2'b11) begin
                // lb/lh/lw and lbu/lhu share the size code in f3[1:0].
                mem_read = f3[1:0] + 2'd1; dmse = ~f3[2];
                alu_op = ALU_ADD; alu_src = 1'b1;
                reg_write = 1'b1; reg_dst = 1'b1; mem_to_reg = 2'b01; ft = FT_I;
            end
            OP_STORE: if (!f3[2] && f3[1:0] != 2'b11) begin
                mem_write = f3[1:0] + 2'd1;
                alu_op = ALU_ADD; alu_src = 1'b1; ft = FT_S;
            end
            OP_IMM: if ((f3 != 3'b001 && f3 != 3'b101) || f7 == 7'b0000000 ||
                        (f3 == 3'b101 && f7 == 7'b0100000)) begin
                alu_or_shift = (f3[1:0] == 2'b01);
                alu_op = arith_op(f3, (f3 == 3'b101) && f7[5]);
                alu_src = 1'b1; reg_write = 1'b1; reg_dst = 1'b1; ft = FT_I;
            end
            OP_REG: if (f7 == 7'b0000000 ||
                        (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))) begin
                alu_or_shift = (f3[1:0] == 2'b01);
                alu_op = arith_op(f3, f7[5]);
                reg_write = 1'b1; reg_dst = 1'b1; ft = FT_R;
            end
            default: ;
        endcase
    end

    assign dec_ctrl = {rs1_z, rs1_pc, alu_or_shift, reg_dst, dmse, alu_op, alu_src,
                       mem_read, mem_write, branch, reg_write, mem_to_reg, ft};

    always_comb begin
        case (ft)
            FT_I:    dec_imm = XLEN'($signed(if_ir[31:20]));
            FT_S:    dec_imm = XLEN'($signed({if_ir[31:25], if_ir[11:7]}));
            FT_B:    dec_imm = XLEN'($signed({if_ir[31], if_ir[7], if_ir[30:25], if_ir[11:8], 1'b0}));
            FT_U:    dec_imm = XLEN'($signed({if_ir[31:12], 12'b0}));
            FT_J:    dec_imm = XLEN'($signed({if_ir[31], if_ir[19:12], if_ir[20], if_ir[30:21], 1'b0}));
            default: dec_imm = '0;
        endcase
    end

    // ---------------- load-use hazard ----------------
    logic uses_rs1, uses_rs2, hazard;
    assign uses_rs1 = !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
    assign uses_rs2 = (opcode == OP_BR || opcode == OP_STORE || opcode == OP_REG);
    assign hazard   = (ex_memread != 2'b00) && (ex_rd != 5'd0) &&
                      ((uses_rs1 && ex_rd == if_ir[19:15]) ||
                       (uses_rs2 && ex_rd == if_ir[24:20]));

    // ---------------- control FSM ----------------
    state_t     state_reg, state_next;
    logic [1:0] cnt_reg, cnt_next;
    logic       id_valid_reg;
    logic       can_adv, load_en, clear_en;

    assign can_adv  = !id_valid_reg || ex_ready;
    assign if_ready = (state_reg == ST_RUN) && !hazard && can_adv;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        load_en    = 1'b0;
        clear_en   = 1'b0;
        if (flush) begin
            clear_en   = 1'b1;
            state_next = ST_RUN;
            cnt_next   = 2'd0;
        end else begin
            case (state_reg)
                ST_RUN: if (can_adv) begin
                    if (if_valid && !hazard) begin
                        load_en = 1'b1;
                    end else begin
                        // Either draining (no input) or the first load-use bubble.
                        clear_en = 1'b1;
                        if (if_valid) begin
                            cnt_next   = BUBBLE_CNT;
                            state_next = (BUBBLE_CNT != 2'd0) ? ST_STALL : ST_RUN;
                        end
                    end
                end
                ST_STALL: if (ex_ready) begin
                    cnt_next = cnt_reg - 2'd1;
                    if (cnt_reg <= 2'd1) begin
                        cnt_next   = 2'd0;
                        state_next = ST_RUN;
                    end
                end
                default: begin
                    state_next = ST_RUN;
                    cnt_next   = 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_RUN;
            cnt_reg   <= 2'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // ---------------- ID/EX register ----------------
    logic [CTRL_W-1:0] id_ctrl_reg;
    logic [4:0]        id_rs1_reg, id_rs2_reg, id_rd_reg;
    logic [XLEN-1:0]   id_imm_reg, id_pc_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || clear_en) begin
            id_valid_reg <= 1'b0;
            id_ctrl_reg  <= '0;
            id_rs1_reg   <= '0;
            id_rs2_reg   <= '0;
            id_rd_reg    <= '0;
            id_imm_reg   <= '0;
            id_pc_reg    <= '0;
        end else if (load_en) begin
            id_valid_reg <= 1'b1;
            id_ctrl_reg  <= dec_ctrl;
            id_rs1_reg   <= if_ir[19:15];
            id_rs2_reg   <= if_ir[24:20];
            id_rd_reg    <= if_ir[11:7];
            id_imm_reg   <= dec_imm;
            id_pc_reg    <= if_pc;
        end
    end

    assign id_valid = id_valid_reg;
    assign id_ctrl  = id_ctrl_reg;
    assign id_rs1   = id_rs1_reg;
    assign id_rs2   = id_rs2_reg;
    assign id_rd    = id_rd_reg;
    assign id_imm   = id_imm_reg;
    assign id_pc    = id_pc_reg;

`ifdef ID_ILLEGAL_TRAP_EN
    // Every legal instruction carries a nonzero ALUOp, so an all-zero
    // bundle identifies exactly the unrecognised encodings.
    logic id_illegal_reg;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || clear_en) begin
            id_illegal_reg <= 1'b0;
        end else if (load_en) begin
            id_illegal_reg <= (dec_ctrl == '0);
        end
    end
    assign id_illegal = id_illegal_reg;
`else
    assign id_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_id_pipe_stage.sv
// Bench for id_pipe_stage: directed vectors, a mnemonic-level reference
// model checked every cycle, plus hand-computed literal expectations.
module tb_id_pipe_stage;
    localparam int LUB = 2;

    logic        clk = 1'b0;
    logic        rst_n, flush, if_valid, ex_ready;
    logic        if_ready, id_valid, id_illegal;
    logic [31:0] if_ir, if_pc, id_imm, id_pc;
    logic [1:0]  ex_memread;
    logic [4:0]  ex_rd, id_rs1, id_rs2, id_rd;
    logic [21:0] id_ctrl;

    int n_tests = 0;
    int n_fail  = 0;

    id_pipe_stage #(.XLEN(32), .ALUOP_W(5), .LU_BUBBLE(LUB)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .if_valid(if_valid),
        .if_ready(if_ready), .if_ir(if_ir), .if_pc(if_pc), .ex_ready(ex_ready),
        .ex_memread(ex_memread), .ex_rd(ex_rd), .id_valid(id_valid),
        .id_ctrl(id_ctrl), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_imm(id_imm), .id_pc(id_pc), .id_illegal(id_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic string mnem(input logic [31:0] ir);
        logic [2:0] f3 = ir[14:12];
        logic [6:0] f7 = ir[31:25];
        case (ir[6:0])
            7'h37: return "lui";
            7'h17: return "auipc";
            7'h6f: return "jal";
            7'h67: return (f3 == 3'd0) ? "jalr" : "bad";
            7'h63: case (f3)
                3'd0: return "beq";  3'd1: return "bne";
                3'd4: return "blt";  3'd5: return "bge";
                3'd6: return "bltu"; 3'd7: return "bgeu";
                default: return "bad";
            endcase
            7'h03: case (f3)
                3'd0: return "lb";  3'd1: return "lh"; 3'd2: return "lw";
                3'd4: return "lbu"; 3'd5: return "lhu";
                default: return "bad";
            endcase
            7'h23: case (f3)
                3'd0: return "sb"; 3'd1: return "sh"; 3'd2: return "sw";
                default: return "bad";
            endcase
            7'h13: case (f3)
                3'd0: return "addi"; 3'd2: return "slti"; 3'd3: return "sltiu";
                3'd4: return "xori"; 3'd6: return "ori";  3'd7: return "andi";
                3'd1: return (f7 == 7'h00) ? "slli" : "bad";
                default: return (f7 == 7'h00) ? "srli" : (f7 == 7'h20) ? "srai" : "bad";
            endcase
            7'h33: case ({f7, f3})
                10'h000: return "add"; 10'h100: return "sub"; 10'h001: return "sll";
                10'h002: return "slt"; 10'h003: return "sltu"; 10'h004: return "xor";
                10'h005: return "srl"; 10'h105: return "sra"; 10'h006: return "or";
                10'h007: return "and";
                default: return "bad";
            endcase
            default: return "bad";
        endcase
    endfunction

    function automatic bit is_load(input string m);
        return m == "lb" || m == "lh" || m == "lw" || m == "lbu" || m == "lhu";
    endfunction
    function automatic bit is_store(input string m);
        return m == "sb" || m == "sh" || m == "sw";
    endfunction
    function automatic bit is_branch(input string m);
        return m == "beq" || m == "bne" || m == "blt" || m == "bge" || m == "bltu" || m == "bgeu";
    endfunction

    function automatic int alu_code(input string m);
        if (m == "add" || m == "addi" || m == "lui" || m == "auipc" || m == "jal" ||
            m == "jalr" || is_load(m) || is_store(m)) return 1;
        if (m == "sub") return 2;
        if (m == "sll" || m == "slli") return 3;
        if (m == "slt" || m == "slti") return 4;
        if (m == "sltu" || m == "sltiu") return 5;
        if (m == "xor" || m == "xori") return 6;
        if (m == "srl" || m == "srli") return 7;
        if (m == "sra" || m == "srai") return 8;
        if (m == "or" || m == "ori") return 9;
        if (m == "and" || m == "andi") return 10;
        return 0;
    endfunction

    typedef struct packed {
        logic [21:0] ctrl;
        logic [31:0] imm;
        logic        bad;
    } dec_t;

    function automatic dec_t model_dec(input logic [31:0] ir);
        string m = mnem(ir);
        int    sir = ir;
        bit    bad = (m == "bad");
        bit    ld = is_load(m), st = is_store(m), br = is_branch(m);
        bit    jmp = (m == "jal" || m == "jalr");
        bit    rtype = !bad && ir[6:0] == 7'h33;
        bit    shf = (m == "sll" || m == "slli" || m == "srl" || m == "srli" ||
                      m == "sra" || m == "srai");
        bit    wr = !(bad || br || st);
        int    ft, aluop, mr, mw, m2r, imm;
        dec_t  d;
        if (bad) ft = 0;
        else if (m == "lui" || m == "auipc") ft = 4;
        else if (m == "jal") ft = 5;
        else if (br) ft = 3;
        else if (st) ft = 2;
        else if (rtype) ft = 0;
        else ft = 1;
        aluop = br ? 16 + int'(ir[14:12]) : alu_code(m);
        mr = !ld ? 0 : (m == "lb" || m == "lbu") ? 1 : (m == "lh" || m == "lhu") ? 2 : 3;
        mw = (m == "sb") ? 1 : (m == "sh") ? 2 : (m == "sw") ? 3 : 0;
        m2r = jmp ? 2 : ld ? 1 : 0;
        case (ft)
            1: imm = sir >>> 20;
            2: imm = ((sir >>> 25) << 5) | ((sir >> 7) & 31);
            3: imm = ((sir >>> 31) << 12) | (((sir >> 7) & 1) << 11) |
                     (((sir >> 25) & 63) << 5) | (((sir >> 8) & 15) << 1);
            4: imm = sir & 32'hFFFFF000;
            5: imm = ((sir >>> 31) << 20) | (((sir >> 12) & 255) << 12) |
                     (((sir >> 20) & 1) << 11) | (((sir >> 21) & 1023) << 1);
            default: imm = 0;
        endcase
        d.ctrl = {m == "lui", m == "auipc" || m == "jal", shf, wr,
                  m == "lb" || m == "lh" || m == "lw", 5'(aluop), !(bad || br || rtype),
                  2'(mr), 2'(mw), br, wr, 2'(m2r), 3'(ft)};
        d.imm = 32'(imm);
        d.bad = bad;
        return d;
    endfunction

    function automatic bit model_hazard(input logic [31:0] ir, input logic [1:0] mr,
                                        input logic [4:0] rd);
        logic [6:0] op = ir[6:0];
        bit r1 = !(op == 7'h37 || op == 7'h17 || op == 7'h6f);
        bit r2 = (op == 7'h63 || op == 7'h23 || op == 7'h33);
        return mr != 2'b00 && rd != 5'd0 &&
               ((r1 && rd == ir[19:15]) || (r2 && rd == ir[24:20]));
    endfunction

    typedef struct packed {
        logic        v;
        logic [21:0] ctrl;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] imm, pc;
        logic        ill;
    } ent_t;

    ent_t m_ent;
    int   m_stall;   // bubble cycles still owed after the first one

    always @(posedge clk or negedge rst_n) begin
        dec_t d;
        if (!rst_n) begin
            m_ent   <= '0;
            m_stall <= 0;
        end else if (flush) begin
            m_ent   <= '0;
            m_stall <= 0;
        end else if (m_stall > 0) begin
            if (ex_ready) m_stall <= m_stall - 1;
        end else if (m_ent.v && !ex_ready) begin
            m_ent <= m_ent;
        end else if (if_valid && model_hazard(if_ir, ex_memread, ex_rd)) begin
            m_ent   <= '0;
            m_stall <= LUB - 1;
        end else if (if_valid) begin
            d = model_dec(if_ir);
            m_ent <= '{v: 1'b1, ctrl: d.ctrl, rs1: if_ir[19:15], rs2: if_ir[24:20],
                       rd: if_ir[11:7], imm: d.imm, pc: if_pc,
`ifdef ID_ILLEGAL_TRAP_EN
                       ill: d.bad};
`else
                       ill: 1'b0};
`endif
        end else begin
            m_ent <= '0;
        end
    end

    always @(negedge clk) begin
        bit exp_rdy;
        exp_rdy = (m_stall == 0) && !model_hazard(if_ir, ex_memread, ex_rd) &&
                  (!m_ent.v || ex_ready);
        chk("cyc_valid", id_valid, m_ent.v);
        chk("cyc_if_ready", if_ready, exp_rdy);
        if (m_ent.v) begin
            chk("cyc_ctrl", id_ctrl, m_ent.ctrl);
            chk("cyc_rs1", id_rs1, m_ent.rs1);
            chk("cyc_rs2", id_rs2, m_ent.rs2);
            chk("cyc_rd", id_rd, m_ent.rd);
            chk("cyc_imm", id_imm, m_ent.imm);
            chk("cyc_pc", id_pc, m_ent.pc);
            chk("cyc_illegal", id_illegal, m_ent.ill);
        end else begin
            chk("cyc_bubble_ctrl", id_ctrl, 0);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] vec [16] = '{
        32'h123453b7, 32'hfffff417, 32'hff9ff0ef, 32'h000080e7,
        32'h0040c183, 32'hffe11203, 32'h0020a023, 32'h0020b023,
        32'h4030d093, 32'h402081b3, 32'h0020e1b3, 32'h0000000f,
        32'h00000013, 32'h00500092, 32'h00a0c663, 32'h0220c1b3
    };

    initial begin
        dec_t d;
        logic exp_ill;
`ifdef ID_ILLEGAL_TRAP_EN
        exp_ill = 1'b1;
`else
        exp_ill = 1'b0;
`endif
        rst_n = 1'b0; flush = 1'b0; if_valid = 1'b0; ex_ready = 1'b1;
        if_ir = 32'h0; if_pc = 32'h0; ex_memread = 2'b00; ex_rd = 5'd0;

        // Pin the reference model with hand-derived values.
        d = model_dec(32'h00500093);
        chk("model_addi_ctrl", d.ctrl, 22'h041821);
        chk("model_addi_imm", d.imm, 32'd5);
        d = model_dec(32'hfe209ee3);
        chk("model_bne_imm", d.imm, 32'hFFFFFFFC);
        d = model_dec(32'hff9ff0ef);
        chk("model_jal_imm", d.imm, 32'hFFFFFFF8);
        d = model_dec(32'h123453b7);
        chk("model_lui_imm", d.imm, 32'h12345000);

        step(); step();
        chk("rst_valid", id_valid, 0);
        chk("rst_ctrl", id_ctrl, 0);
        #2 rst_n = 1'b1;
        #1 chk("rst_if_ready", if_ready, 1);

        // addi x1,x0,5
        if_valid = 1'b1; if_ir = 32'h00500093; if_pc = 32'h100;
        step();
        chk("addi_ctrl", id_ctrl, 22'h041821);
        chk("addi_imm", id_imm, 5);
        chk("addi_rd", id_rd, 1);
        chk("addi_pc", id_pc, 32'h100);

        // sh x2,4(x1)
        if_ir = 32'h00209223; if_pc = 32'h104;
        step();
        chk("sh_ctrl", id_ctrl, 22'h001902);
        chk("sh_imm", id_imm, 4);

        // load-use: add x3,x2,x1 behind a load to x2
        ex_memread = 2'b11; ex_rd = 5'd2; if_ir = 32'h001101b3; if_pc = 32'h108;
        #1 chk("lu_ready0", if_ready, 0);
        step();
        chk("lu_bubble1", id_valid, 0);
        ex_memread = 2'b00;
        #1 chk("lu_ready1", if_ready, 0);
        step();
        chk("lu_bubble2", id_valid, 0);
        chk("lu_ready2", if_ready, 1);
        step();
        chk("lu_add_valid", id_valid, 1);
        chk("lu_add_ctrl", id_ctrl, 22'h041020);
        chk("lu_add_rd", id_rd, 3);

        // hold for 3 cycles
        ex_ready = 1'b0; if_ir = 32'h00500293; if_pc = 32'h10c;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_pc", id_pc, 32'h108);
            chk("hold_ready", if_ready, 0);
        end
        ex_ready = 1'b1;
        step();
        chk("after_hold_pc", id_pc, 32'h10c);

        // flush during STALL
        ex_memread = 2'b10; ex_rd = 5'd5; if_ir = 32'h00028333; if_pc = 32'h110;
        step();
        chk("stall_valid", id_valid, 0);
        ex_memread = 2'b00; ex_ready = 1'b0; flush = 1'b1; if_ir = 32'h00500093;
        step();
        flush = 1'b0;
        chk("flush_stall_valid", id_valid, 0);
        #1 chk("flush_stall_ready", if_ready, 1);
        ex_ready = 1'b1;

        // flush of a held instruction
        if_pc = 32'h120;
        step();
        ex_ready = 1'b0; flush = 1'b1;
        step();
        chk("flush_hold_valid", id_valid, 0);
        flush = 1'b0; ex_ready = 1'b1;

        // flush and hazard in the same cycle
        ex_memread = 2'b01; ex_rd = 5'd5; if_ir = 32'h00028333; flush = 1'b1;
        step();
        flush = 1'b0; ex_memread = 2'b00; ex_ready = 1'b0;
        #1 chk("flush_hz_ready", if_ready, 1);
        ex_ready = 1'b1;

        // bne x1,x2,-4
        if_ir = 32'hfe209ee3; if_pc = 32'h130;
        step();
        chk("bne_ctrl", id_ctrl, 22'h011043);
        chk("bne_imm", id_imm, 32'hFFFFFFFC);

        // all-ones word
        if_ir = 32'hFFFFFFFF; if_pc = 32'h134;
        step();
        chk("ill_valid", id_valid, 1);
        chk("ill_ctrl", id_ctrl, 0);
        chk("ill_flag", id_illegal, exp_ill);

        // decode sweep, checked by the model each cycle
        for (int i = 0; i < 16; i++) begin
            if_ir = vec[i]; if_pc = 32'h200 + 32'(4 * i);
            step();
            $display("[TB] ir=%08h pc=%08h ctrl=%06h imm=%08h ill=%0d", vec[i], id_pc, id_ctrl, id_imm, id_illegal);
        end

        // asynchronous reset with a live instruction held
        if_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", id_valid, 0);
        chk("arst_pc", id_pc, 0);
        chk("arst_rd", id_rd, 0);
        rst_n = 1'b1;
        step();

        // asynchronous reset in the middle of a stall
        if_valid = 1'b1; ex_memread = 2'b11; ex_rd = 5'd1; if_ir = 32'h001101b3; if_pc = 32'h300;
        step();
        ex_ready = 1'b0; ex_memread = 2'b00;
        #1 chk("stall_pre_rst_ready", if_ready, 0);
        #1 rst_n = 1'b0;
        #1;
        chk("stall_rst_valid", id_valid, 0);
        chk("stall_rst_ready", if_ready, 1);
        rst_n = 1'b1;
        ex_ready = 1'b1;
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
